// File: rtl/circuit_arb.sv
// Two-requester round-robin burst arbiter in front of a pipelined datapath.
// In-flight beats are tracked so each result is tagged with its owner.
module circuit_arb #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s0_valid,
    input  logic [W-1:0] s0_x,
    input  logic         s0_last,
    output logic         s0_ready,
    input  logic         s1_valid,
    input  logic [W-1:0] s1_x,
    input  logic         s1_last,
    output logic         s1_ready,
    output logic         c_en,
    output logic [W-1:0] c_x,
    output logic         c_clr,
    input  logic [W-1:0] c_y,
    output logic         r_valid,
    output logic         r_id,
    output logic [W-1:0] r_y
);
    typedef enum logic [1:0] {IDLE, CLR, BURST, DRAIN} state_t;

    state_t         state;
    logic           ptr;
    logic           grant;
    logic [W-1:0]   cx_q;
    logic [LAT-1:0] trk_v;
    logic [LAT-1:0] trk_id;
    logic [LAT-1:0] trk_v_nxt;
    logic [LAT-1:0] trk_id_nxt;
    logic           g_valid;
    logic           g_ready;
    logic           g_last;
    logic [W-1:0]   g_x;
    logic           beat;

    always_comb begin
        g_valid = s0_valid;
        g_ready = s0_ready;
        g_last  = s0_last;
        g_x     = s0_x;
        if (grant) begin
            g_valid = s1_valid;
            g_ready = s1_ready;
            g_last  = s1_last;
            g_x     = s1_x;
        end
    end

    assign beat = g_valid & g_ready;
    assign c_en = beat;
    assign c_x  = beat ? g_x : cx_q;

    // Stage 0 receives the current beat; stage LAT-1 is the result stage.
    assign trk_v_nxt  = (trk_v << 1) | LAT'(beat);
    assign trk_id_nxt = (trk_id << 1) | LAT'(beat & grant);

    assign r_valid = trk_v[LAT-1];
    assign r_id    = trk_id[LAT-1];
    assign r_y     = c_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            grant    <= 1'b0;
            c_clr    <= 1'b0;
            s0_ready <= 1'b0;
            s1_ready <= 1'b0;
            cx_q     <= '0;
            trk_v    <= '0;
            trk_id   <= '0;
        end else begin
            trk_v  <= trk_v_nxt;
            trk_id <= trk_id_nxt;
            c_clr  <= 1'b0;
            if (beat) cx_q <= g_x;
            unique case (state)
                IDLE: begin
                    if (s0_valid | s1_valid) begin
                        grant <= (s0_valid & s1_valid) ? ptr : s1_valid;
                        c_clr <= 1'b1;
                        state <= CLR;
                    end
                end
                CLR: begin
                    s0_ready <= ~grant;
                    s1_ready <= grant;
                    state    <= BURST;
                end
                BURST: begin
                    if (beat & g_last) begin
                        ptr      <= ~grant;
                        s0_ready <= 1'b0;
                        s1_ready <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave as the final result is presented.
                    if (trk_v_nxt == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/circuit_arb.md
CIRCUIT_ARB -- requirements
Module: circuit_arb

Interface
REQ-001 Parameter W, default 32: sample and result width in bits.
REQ-002 Parameter LAT, default 1: cycles from datapath en-beat to the corresponding valid y; legal range 1..8.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s0_valid / s1_valid  input  1  requester 0/1 offers a sample.
REQ-006 s0_x / s1_x  input  W  requester 0/1 sample.
REQ-007 s0_last / s1_last  input  1  marks the final sample of the requester's burst.
REQ-008 s0_ready / s1_ready  output  1  arbiter accepts the sample this cycle.
REQ-009 c_en  output  1  datapath enable.
REQ-010 c_x  output  W  datapath sample.
REQ-011 c_clr  output  1  synchronous datapath clear pulse.
REQ-012 c_y  input  W  datapath result.
REQ-013 r_valid  output  1  result valid.
REQ-014 r_id  output  1  requester that owns the result.
REQ-015 r_y  output  W  result data.

Function
REQ-016 FSM states SHALL be IDLE, CLR, BURST, DRAIN, with a round-robin priority bit ptr.
REQ-017 IDLE: if exactly one requester has valid=1, grant it; if both, grant requester ptr; go to CLR; no valid -> stay.
REQ-018 CLR: c_clr=1 for exactly one cycle, no ready asserted; next state BURST.
REQ-019 BURST: s<g>_ready=1 for the granted requester only; the other requester's ready SHALL stay 0.
REQ-020 Beat = granted valid & ready; on a beat c_en=1 and c_x=granted x in the same cycle; otherwise c_en=0, c_x holds its last value.
REQ-021 Beat with last=1 -> DRAIN; ptr <= ~grant, so the other requester wins the next tie.
REQ-022 Bursts SHALL NOT be preempted; valid=0 mid-burst stalls without leaving BURST.
REQ-023 Each beat pushes {1, grant} into a LAT-deep tracking shift register; stage LAT drives r_valid and r_id; r_y = c_y combinationally.
REQ-024 r_valid SHALL rise exactly LAT cycles after each beat, one pulse per beat, in beat order.
REQ-025 DRAIN: wait until the tracking register is empty (LAT cycles after the last beat), then go to IDLE; no ready or c_clr in DRAIN.
REQ-026 Back-to-back bursts: minimum gap from the last beat of burst N to the first beat of burst N+1 is LAT+2 cycles (DRAIN, IDLE, CLR).
REQ-027 A single-beat burst (first beat has last=1) SHALL follow CLR -> BURST (1 beat) -> DRAIN.
REQ-028 Requester valid changes while in CLR, DRAIN or IDLE (before grant) SHALL NOT alter the current grant.

Reset
REQ-029 rst=1 SHALL force state IDLE, ptr=0, grant=0, tracking register empty, and c_en, c_clr, c_x, s0_ready, s1_ready, r_valid, r_id all 0, immediately and independently of clk.
REQ-030 Reset mid-burst SHALL discard all in-flight results (no r_valid after release); the first cycle after release is IDLE.

Verification
REQ-031 Only s0 requests 3 samples 5,7,9 with last on 9 (LAT=1) -> c_clr pulse, then c_en beats x=5,7,9; r_valid pulses with r_id=0 one cycle after each beat; DRAIN, then IDLE.
REQ-032 s0 and s1 both valid from reset, each bursting 2 samples -> s0 served first (ptr=0), then s1, then s0 again; s1_ready=0 throughout s0's burst.
REQ-033 Granted requester drops valid for 3 cycles mid-burst -> c_en=0 for those cycles, state stays BURST, no grant change.
REQ-034 LAT=4, single-beat burst from s1 -> r_valid with r_id=1 exactly 4 cycles after the beat; IDLE reached on the cycle after r_valid.
REQ-035 rst asserted one cycle after the second beat of a 4-beat burst -> all outputs 0 asynchronously; no r_valid after release; the next grant goes to s0.
REQ-036 r_y equals c_y on every r_valid cycle; count of r_valid pulses equals count of beats across 100 random bursts.
